piso_stream: RTL

- Parametrised parallel-in serial-out shift register with a valid/ready load handshake, run-time bit-order select and a shift-enable tick for pacing.
- Accepts a WIDTH-bit word, captures it, and emits it one bit per enabled cycle with valid and last-bit flags.
- Supports back-to-back words with no idle gap.
- Sits between a parallel producer (register file, FIFO) and a serial link or bit-serial datapath.

---
 rtl/piso_stream.sv | 117 +++++++++++
 1 files changed

// File: rtl/piso_stream.sv
// piso_stream: parallel-in serial-out shifter with a valid/ready load
// handshake, per-word bit-order select and a shift-enable pacing tick.
// Back-to-back words stream with no idle cycle between them.
module piso_stream #(
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [WIDTH-1:0] parallel_in,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic             lsb_first,
    input  logic             shift_en,
    output logic             serial_out,
    output logic             serial_valid,
    output logic             serial_last,
    output logic             busy
);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

    state_t             state, state_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic [WIDTH-1:0]   shreg, shreg_n;
    logic               order_lsb, order_lsb_n;
    logic               out_n, valid_n, last_n;
    logic               accept;

    // Ready when empty, or when the final bit leaves on this edge so the
    // next word can follow without a gap.
    assign load_ready = (state == IDLE) ||
                        (state == SHIFT && serial_last && shift_en);
    assign accept     = load_valid && load_ready;
    assign busy       = serial_valid;

    // Next-state and next-output decode for load, shift and end of word.
    always_comb begin
        // NOTE: every output gets a hold value first so no path leaves it
        // unassigned; otherwise synthesis infers a latch.
        state_n     = state;
        cnt_n       = cnt;
        shreg_n     = shreg;
        order_lsb_n = order_lsb;
        out_n       = serial_out;
        valid_n     = serial_valid;
        last_n      = serial_last;

        if (accept) begin
            // Capture word and order; first bit becomes visible next cycle.
            state_n     = SHIFT;
            cnt_n       = '0;
            shreg_n     = parallel_in;
            order_lsb_n = lsb_first;
            out_n       = lsb_first ? parallel_in[0] : parallel_in[WIDTH-1];
            valid_n     = 1'b1;
            last_n      = 1'b0;
        end else if (state == SHIFT && shift_en) begin
            if (serial_last) begin
                // Word finished and nothing waiting: fall back to idle.
                state_n = IDLE;
                cnt_n   = '0;
                shreg_n = '0;
                out_n   = 1'b0;
                valid_n = 1'b0;
                last_n  = 1'b0;
            end else begin
                // Shift toward the output end chosen when the word loaded.
                cnt_n  = cnt + CNT_W'(1);
                last_n = ((cnt + CNT_W'(1)) == LAST_IDX);
                if (order_lsb) begin
                    shreg_n = {1'b0, shreg[WIDTH-1:1]};
                    out_n   = shreg[1];
                end else begin
                    shreg_n = {shreg[WIDTH-2:0], 1'b0};
                    out_n   = shreg[WIDTH-2];
                end
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state <= IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so every
            // flop samples the pre-edge values of the others.
            state <= state_n;
        end
    end

    // Datapath and registered serial outputs; reset aborts any word in flight.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            cnt          <= '0;
            shreg        <= '0;
            order_lsb    <= 1'b0;
            serial_out   <= 1'b0;
            serial_valid <= 1'b0;
            serial_last  <= 1'b0;
        end else begin
            cnt          <= cnt_n;
            shreg        <= shreg_n;
            order_lsb    <= order_lsb_n;
            serial_out   <= out_n;
            serial_valid <= valid_n;
            serial_last  <= last_n;
        end
    end

endmodule
